// File: rtl/note_judge.sv
// Two-track rhythm-game judge: per-track note FIFOs, timing-window judgment,
// and score/combo bookkeeping driven by a small game-phase FSM.

module note_lane #(
    parameter int TRAVEL_MS  = 1000,
    parameter int PERFECT_MS = 50,
    parameter int GOOD_MS    = 120,
    parameter int DEPTH      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spawn_en,
    input  logic        judge_en,
    input  logic        spawn,
    input  logic        btn,
    input  logic [31:0] cur_time,
    input  logic [31:0] pitch,
    output logic [1:0]  code,
    output logic [31:0] head_pitch,
    output logic        empty,
    output logic        pushed,
    output logic        drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic signed [32:0] PERF_W = 33'(PERFECT_MS);
    localparam logic signed [32:0] GOOD_W = 33'(GOOD_MS);

    typedef struct packed {
        logic [31:0] target;
        logic [31:0] pitch;
    } note_t;

    note_t             mem [DEPTH];
    note_t             head;
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [AW:0]       count;
    logic signed [32:0] d, mag;
    logic              full, pop;

    assign head       = mem[rd_ptr];
    assign head_pitch = head.pitch;
    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(DEPTH));

    // 33-bit signed distance from the hit line; positive means late
    assign d   = $signed({1'b0, cur_time}) - $signed({1'b0, head.target});
    assign mag = d[32] ? -d : d;

    // Expiry outranks a press; early presses beyond the good window fall through to 0
    always_comb begin
        code = 2'd0;
        if (judge_en && !empty) begin
            if (d > GOOD_W)
                code = 2'd3;
            else if (btn && mag <= PERF_W)
                code = 2'd1;
            else if (btn && mag <= GOOD_W)
                code = 2'd2;
        end
    end

    assign pop    = (code != 2'd0);
    assign pushed = spawn_en && spawn && (!full || pop);
    assign drop   = spawn_en && spawn && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pushed) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({pushed, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is gated by count, so it needs no reset
    always_ff @(posedge clk) begin
        if (pushed)
            mem[wr_ptr] <= '{target: cur_time + 32'(TRAVEL_MS), pitch: pitch};
    end
endmodule

module note_judge #(
    parameter int TRAVEL_MS  = 1000,
    parameter int PERFECT_MS = 50,
    parameter int GOOD_MS    = 120,
    parameter int DEPTH      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_cur_time,
    input  logic        i_note_t1,
    input  logic        i_note_t2,
    input  logic [31:0] i_pitch,
    input  logic        i_btn_t1,
    input  logic        i_btn_t2,
    input  logic        i_game_end,
    output logic [1:0]  o_judge_t1,
    output logic [1:0]  o_judge_t2,
    output logic [31:0] o_hit_pitch,
    output logic [15:0] o_score,
    output logic [7:0]  o_combo,
    output logic [7:0]  o_max_combo,
    output logic        o_overflow,
    output logic        o_done
);
    localparam int NUM_LANES = 2;

    typedef enum logic [1:0] {IDLE, PLAY, DRAIN, DONE} state_t;
    state_t state;

    logic [NUM_LANES-1:0]        spawn, btn, empty, pushed, drop, hit;
    logic [NUM_LANES-1:0][1:0]   code;
    logic [NUM_LANES-1:0][31:0]  head_pitch;
    logic                        spawn_en, judge_en, any_miss;
    logic [2:0]                  pts;
    logic [1:0]                  hits;
    logic [16:0]                 score_sum;
    logic [8:0]                  combo_sum;
    logic [15:0]                 score_next;
    logic [7:0]                  combo_next;

    assign spawn    = {i_note_t2, i_note_t1};
    assign btn      = {i_btn_t2, i_btn_t1};
    assign spawn_en = (state != DONE);
    assign judge_en = (state == PLAY) || (state == DRAIN);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        note_lane #(
            .TRAVEL_MS (TRAVEL_MS),
            .PERFECT_MS(PERFECT_MS),
            .GOOD_MS   (GOOD_MS),
            .DEPTH     (DEPTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .spawn_en  (spawn_en),
            .judge_en  (judge_en),
            .spawn     (spawn[g]),
            .btn       (btn[g]),
            .cur_time  (i_cur_time),
            .pitch     (i_pitch),
            .code      (code[g]),
            .head_pitch(head_pitch[g]),
            .empty     (empty[g]),
            .pushed    (pushed[g]),
            .drop      (drop[g])
        );
        assign hit[g] = (code[g] == 2'd1) || (code[g] == 2'd2);
    end

    always_comb begin
        pts      = 3'd0;
        hits     = 2'd0;
        any_miss = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            case (code[i])
                2'd1: begin pts = pts + 3'd2; hits = hits + 2'd1; end
                2'd2: begin pts = pts + 3'd1; hits = hits + 2'd1; end
                2'd3: any_miss = 1'b1;
                default: ;
            endcase
        end
        score_sum  = {1'b0, o_score} + 17'(pts);
        combo_sum  = {1'b0, o_combo} + 9'(hits);
        score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        if (any_miss)
            combo_next = 8'd0;
        else
            combo_next = combo_sum[8] ? 8'hFF : combo_sum[7:0];
    end

    // Lane codes are already forced to 0 outside PLAY/DRAIN, which freezes everything in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            o_judge_t1  <= 2'd0;
            o_judge_t2  <= 2'd0;
            o_hit_pitch <= 32'd0;
            o_score     <= 16'd0;
            o_combo     <= 8'd0;
            o_max_combo <= 8'd0;
            o_overflow  <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_judge_t1 <= code[0];
            o_judge_t2 <= code[1];
            o_score    <= score_next;
            o_combo    <= combo_next;
            if (combo_next > o_max_combo)
                o_max_combo <= combo_next;
            if (hit[0])
                o_hit_pitch <= head_pitch[0];
            else if (hit[1])
                o_hit_pitch <= head_pitch[1];
            if (|drop)
                o_overflow <= 1'b1;

            case (state)
                IDLE:  if (|spawn) state <= PLAY;
                PLAY:  if (i_game_end) state <= DRAIN;
                DRAIN: if (&empty && !(|pushed)) begin
                    state  <= DONE;
                    o_done <= 1'b1;
                end
                DONE:  state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_note_judge.sv
// Directed plus randomized checks of note_judge against a queue-based
// model of the game rules.

module tb_note_judge;
    localparam int TRAVEL = 1000;
    localparam int PERF   = 50;
    localparam int GOOD   = 120;
    localparam int DEPTH  = 8;
    localparam int S_IDLE = 0, S_PLAY = 1, S_DRAIN = 2, S_DONE = 3;

    logic        clk, rst;
    logic [31:0] i_cur_time, i_pitch;
    logic        i_note_t1, i_note_t2, i_btn_t1, i_btn_t2, i_game_end;
    logic [1:0]  o_judge_t1, o_judge_t2;
    logic [31:0] o_hit_pitch;
    logic [15:0] o_score;
    logic [7:0]  o_combo, o_max_combo;
    logic        o_overflow, o_done;

    note_judge dut (
        .clk(clk), .rst(rst), .i_cur_time(i_cur_time),
        .i_note_t1(i_note_t1), .i_note_t2(i_note_t2), .i_pitch(i_pitch),
        .i_btn_t1(i_btn_t1), .i_btn_t2(i_btn_t2), .i_game_end(i_game_end),
        .o_judge_t1(o_judge_t1), .o_judge_t2(o_judge_t2), .o_hit_pitch(o_hit_pitch),
        .o_score(o_score), .o_combo(o_combo), .o_max_combo(o_max_combo),
        .o_overflow(o_overflow), .o_done(o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { bit [31:0] t; bit [31:0] p; } note_t;
    note_t q1[$], q2[$];
    int m_st, m_score, m_combo, m_maxc, m_j1, m_j2;
    bit [31:0] m_hitp;
    bit m_ovf, m_done;
    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("judge_t1", 32'(o_judge_t1), 32'(m_j1));
        chk("judge_t2", 32'(o_judge_t2), 32'(m_j2));
        chk("score", 32'(o_score), 32'(m_score));
        chk("combo", 32'(o_combo), 32'(m_combo));
        chk("max_combo", 32'(o_max_combo), 32'(m_maxc));
        chk("hit_pitch", o_hit_pitch, m_hitp);
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
        chk("done", 32'(o_done), 32'(m_done));
    endtask

    function automatic int judge(bit [31:0] tgt, bit [31:0] now, bit press);
        longint d, ad;
        d  = longint'({32'h0, now}) - longint'({32'h0, tgt});
        ad = (d < 0) ? -d : d;
        if (d > GOOD) return 3;
        if (!press) return 0;
        if (ad <= PERF) return 1;
        if (ad <= GOOD) return 2;
        return 0;
    endfunction

    function automatic int pts_of(int c);
        return (c == 1) ? 2 : (c == 2) ? 1 : 0;
    endfunction

    task automatic model_clear();
        q1.delete(); q2.delete();
        m_st = S_IDLE; m_score = 0; m_combo = 0; m_maxc = 0;
        m_j1 = 0; m_j2 = 0; m_hitp = 0; m_ovf = 0; m_done = 0;
    endtask

    task automatic step(input bit s1, input bit s2, input bit b1, input bit b2,
                        input bit ge, input bit [31:0] t, input bit [31:0] pitch);
        int c1, c2, hits, sum;
        bit push1, push2;
        note_t n;
        i_cur_time = t; i_pitch = pitch; i_note_t1 = s1; i_note_t2 = s2;
        i_btn_t1 = b1; i_btn_t2 = b2; i_game_end = ge;

        c1 = 0; c2 = 0; push1 = 0; push2 = 0;
        if (m_st == S_PLAY || m_st == S_DRAIN) begin
            if (q1.size() > 0) c1 = judge(q1[0].t, t, b1);
            if (q2.size() > 0) c2 = judge(q2[0].t, t, b2);
        end
        if (m_st != S_DONE) begin
            if (s1) begin
                if (q1.size() - int'(c1 != 0) < DEPTH) push1 = 1; else m_ovf = 1;
            end
            if (s2) begin
                if (q2.size() - int'(c2 != 0) < DEPTH) push2 = 1; else m_ovf = 1;
            end
        end
        if (c1 == 1 || c1 == 2) m_hitp = q1[0].p;
        else if (c2 == 1 || c2 == 2) m_hitp = q2[0].p;

        case (m_st)
            S_IDLE:  if (s1 || s2) m_st = S_PLAY;
            S_PLAY:  if (ge) m_st = S_DRAIN;
            S_DRAIN: if (q1.size() == 0 && q2.size() == 0 && !push1 && !push2) begin
                m_st = S_DONE; m_done = 1;
            end
            default: ;
        endcase

        if (c1 != 0) void'(q1.pop_front());
        if (c2 != 0) void'(q2.pop_front());
        n.t = t + TRAVEL; n.p = pitch;
        if (push1) q1.push_back(n);
        if (push2) q2.push_back(n);

        sum = m_score + pts_of(c1) + pts_of(c2);
        m_score = (sum > 65535) ? 65535 : sum;
        hits = int'(c1 == 1 || c1 == 2) + int'(c2 == 1 || c2 == 2);
        if (c1 == 3 || c2 == 3) m_combo = 0;
        else m_combo = (m_combo + hits > 255) ? 255 : m_combo + hits;
        if (m_combo > m_maxc) m_maxc = m_combo;
        m_j1 = c1; m_j2 = c2;

        @(posedge clk); #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_note_t1 = 0; i_note_t2 = 0; i_btn_t1 = 0; i_btn_t2 = 0; i_game_end = 0;
        model_clear();
        #1;
        check_all();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    bit [31:0] now;

    initial begin
        rst = 1'b1; i_cur_time = 0; i_pitch = 0;
        i_note_t1 = 0; i_note_t2 = 0; i_btn_t1 = 0; i_btn_t2 = 0; i_game_end = 0;
        model_clear();
        @(posedge clk); #1;
        check_all();
        rst = 1'b0;

        // perfect hit on track 1
        step(1, 0, 0, 0, 0, 1000, 32'hA1);
        step(0, 0, 1, 0, 0, 2030, 0);
        chk("req030_judge", 32'(o_judge_t1), 32'd1);
        chk("req030_score", 32'(o_score), 32'd2);
        chk("req030_pitch", o_hit_pitch, 32'hA1);
        step(0, 0, 0, 0, 0, 2031, 0);

        // good hit, early press ignored, expiry boundary on track 2
        step(0, 1, 0, 0, 0, 3000, 32'hB2);
        step(0, 0, 0, 1, 0, 4100, 0);
        chk("req031_good", 32'(o_judge_t2), 32'd2);
        step(0, 1, 0, 0, 0, 5000, 32'hB3);
        step(0, 0, 0, 1, 0, 5870, 0);
        step(0, 0, 0, 0, 0, 6120, 0);
        step(0, 0, 0, 0, 0, 6121, 0);
        chk("req031_miss", 32'(o_judge_t2), 32'd3);

        // overflow on ninth spawn, then a push accepted alongside an expiry pop
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, 7000 + i, 32'(100 + i));
        chk("req032_ovf", 32'(o_overflow), 32'd1);
        step(1, 0, 0, 0, 0, 8121, 32'h77);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 9200, 0);

        // double perfect, then perfect with a simultaneous miss
        step(1, 0, 0, 0, 0, 10000, 32'hC1);
        step(0, 1, 0, 0, 0, 10001, 32'hC2);
        step(0, 0, 1, 1, 0, 11010, 0);
        chk("req033_pitch", o_hit_pitch, 32'hC1);
        step(0, 1, 0, 0, 0, 11800, 32'hD2);
        step(1, 0, 0, 0, 0, 12000, 32'hD1);
        step(0, 0, 1, 0, 0, 13000, 0);
        chk("req033_combo", 32'(o_combo), 32'd0);

        // game end with three pending notes, then frozen in DONE
        step(1, 0, 0, 0, 0, 14000, 32'hE1);
        step(0, 1, 0, 0, 0, 14001, 32'hE2);
        step(1, 0, 0, 0, 0, 14002, 32'hE3);
        step(0, 0, 0, 0, 1, 14003, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 15200, 0);
        chk("req034_done", 32'(o_done), 32'd1);
        step(1, 1, 1, 1, 1, 15300, 32'hEE);
        step(0, 0, 1, 1, 1, 16300, 0);

        // mid-game reset discards pending notes and score
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 20000 + i, 32'(200 + i));
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 21010 + i, 0);
        chk("req035_score10", 32'(o_score), 32'd10);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 21015 + i, 32'(300 + i));
        do_reset();
        step(0, 0, 1, 1, 0, 21100, 0);
        step(0, 1, 0, 0, 0, 21200, 32'hF0);
        step(0, 0, 0, 0, 0, 22100, 0);
        chk("req035_nojudge", 32'(o_judge_t1), 32'd0);

        // randomized play
        now = 22100;
        for (int i = 0; i < 500; i++) begin
            now = now + $urandom_range(1, 20);
            step($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 0, now, $urandom);
        end
        for (int i = 0; i < 30; i++) begin
            now = now + 2000;
            step(0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1, now, 0);
        end
        chk("rand_done", 32'(o_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
